mips_mem_arbiter: RTL
=====================

# mips_mem_arbiter

Single-port memory controller that shares one 1024 x 32 word memory between three requesters of the two-phase MIPS32 pipeline: a bench/boot loader port, the MEM-stage data port (LW/SW), and the IF-stage instruction fetch port. It grants at most one access per cycle, returns registered read data one cycle after grant, and prevents fetch starvation under back-to-back data traffic. It replaces the pipeline's direct `Mem[]` indexing; fetch and MEM stages stall on missing grant/valid.

## Interface
- `AW`, 10, word-address width (memory depth 2**AW)
- `DW`, 32, data width
- `STARVE_LIMIT`, 4, consecutive denied fetch cycles after which fetch outranks data
- `clk1`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ld_req`, `ld_we`  in  1  loader request / write enable
- `ld_addr`  in  AW  loader word address
- `ld_wdata`  in  DW  loader write data
- `ld_gnt`, `ld_rvalid`  out  1  loader grant pulse / read-data valid
- `dm_req`, `dm_we`  in  1  data-port request / write enable
- `dm_addr`  in  AW; `dm_wdata`  in  DW
- `dm_gnt`, `dm_rvalid`  out  1
- `if_req`  in  1  fetch request (read-only port)
- `if_addr`  in  AW
- `if_gnt`, `if_rvalid`  out  1
- `rdata`  out  DW  shared registered read data, qualified by exactly one `*_rvalid`
- `conflict_cnt`  out  16  saturating count of cycles with `dm_req && if_req`

## Operation
- Requester asserts `req` with stable `addr`/`we`/`wdata` and holds them until its `gnt` is high at a rising edge; the access is performed in that grant cycle. Deasserting `req` before grant withdraws it (legal).
- Priority per cycle: loader > (fetch if `starve_cnt == STARVE_LIMIT`) > data > fetch.
- `starve_cnt` (3 bits, saturating at `STARVE_LIMIT`): increments when `if_req && !if_gnt`; clears when `if_gnt` or `!if_req`.
- Exactly zero or one `gnt` high per cycle; `gnt` is combinational from current requests and registered state.
- Write grant: memory written at that edge; no `rvalid`. Read grant: `rdata` and that port's `rvalid` update at the next edge and hold for one cycle.
- `rdata` holds its last value when no `rvalid` is high.
- `conflict_cnt` stops at 16'hFFFF.
- Memory contents are not reset; no initialization.

## Timing
- Reset values: all `gnt` 0, all `rvalid` 0, `rdata` 0, `conflict_cnt` 0, `starve_cnt` 0.
- Read latency: 1 cycle from grant edge to `rvalid`; throughput one access per cycle, back-to-back grants allowed, including to the same port.
- Write at cycle t, read of same address granted at t+1: returns the new data.
- `rst` asserted while a read is in flight: the pending `rvalid` is suppressed; no write is performed in a cycle with `rst` high.
- Loader with continuous requests starves both other ports indefinitely (by design: boot-time only).
- Worst-case fetch wait with continuous data traffic, no loader: `STARVE_LIMIT` cycles, then granted.

## Structure
- Package `mips_mem_pkg`: `AW`/`DW` defaults, requester enum (`REQ_LD`, `REQ_DM`, `REQ_IF`), memory depth constant.
- Sub-module `mips_mem_bank`: single-port synchronous RAM (we, addr, wdata, registered rdata), 2**AW x DW.
- Top holds priority logic, starvation counter, rvalid owner register (2-bit enum + valid), conflict counter.

## Test plan
- Loader writes 32'h2801000a to addr 0, 32'hfc000000 to addr 8; fetch reads 0 and 8 -> `if_rvalid` one cycle after each `if_gnt`, `rdata` = written values.
- `ld_req` and `dm_req` and `if_req` together for one cycle -> only `ld_gnt`; `conflict_cnt` = 1.
- `dm_req` and `if_req` held high for 10 cycles, STARVE_LIMIT=4 -> `dm_gnt` cycles 0-3, `if_gnt` cycle 4, `dm_gnt` cycles 5-8, `if_gnt` cycle 9; `conflict_cnt` = 10.
- Data write 32'h1E to addr 5 at cycle t, fetch read addr 5 at t+1 -> `rdata` = 32'h1E with `if_rvalid` at t+2.
- Read granted, `rst` high next cycle -> no `rvalid`, all outputs at reset values; after release, a fresh read completes normally.
- Force `conflict_cnt` region to 16'hFFFF (65535 conflict cycles) then one more conflict -> stays 16'hFFFF.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared widths, depth and requester encoding for the MIPS memory arbiter
package mips_mem_pkg;
    localparam int AW_DEF           = 10;
    localparam int DW_DEF           = 32;
    localparam int MEM_DEPTH        = 2 ** AW_DEF;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        REQ_LD = 2'd0,
        REQ_DM = 2'd1,
        REQ_IF = 2'd2
    } req_e;
endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - request/grant/read-data bundle for loader, data and fetch ports
interface mips_mem_arbiter_if
    import mips_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();
    logic          ld_req;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;

    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;

    logic [DW-1:0] rdata;

    modport master (
        output ld_req, ld_we, ld_addr, ld_wdata,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output if_req, if_addr,
        input  ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid, rdata
    );

    modport slave (
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  if_req, if_addr,
        output ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid, rdata
    );
endinterface

// File: rtl/mips_mem_bank.sv
// rtl/mips_mem_bank.sv - single-port synchronous RAM with registered read data that holds between reads
module mips_mem_bank #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (rst) begin
            rdata_d = '0;
        end else if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Array contents are deliberately never reset; only the output register is.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we && !rst) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - one-access-per-cycle arbiter for loader, MEM-stage data and IF-stage fetch
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk1,
    input  logic               rst,
    mips_mem_arbiter_if.slave  bus,
    output logic [15:0]        conflict_cnt
);
    logic          ld_gnt, dm_gnt, if_gnt;
    logic          fetch_urgent;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    logic [2:0]  starve_cnt_d, starve_cnt_q;
    req_e        owner_d, owner_q;
    logic        rvalid_d, rvalid_q;
    logic [15:0] conflict_cnt_d, conflict_cnt_q;

    assign fetch_urgent = (starve_cnt_q == 3'(STARVE_LIMIT));

    always_comb begin
        ld_gnt = 1'b0;
        dm_gnt = 1'b0;
        if_gnt = 1'b0;
        if (!rst) begin
            if (bus.ld_req) begin
                ld_gnt = 1'b1;
            end else if (bus.if_req && (fetch_urgent || !bus.dm_req)) begin
                if_gnt = 1'b1;
            end else if (bus.dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = bus.if_addr;
        mem_wdata = bus.dm_wdata;
        mem_we    = 1'b0;
        if (ld_gnt) begin
            mem_addr  = bus.ld_addr;
            mem_wdata = bus.ld_wdata;
            mem_we    = bus.ld_we;
        end else if (dm_gnt) begin
            mem_addr  = bus.dm_addr;
            mem_wdata = bus.dm_wdata;
            mem_we    = bus.dm_we;
        end
        mem_re = (ld_gnt || dm_gnt || if_gnt) && !mem_we;
    end

    always_comb begin
        owner_d        = owner_q;
        rvalid_d       = mem_re;
        starve_cnt_d   = 3'd0;
        conflict_cnt_d = conflict_cnt_q;
        if (ld_gnt) begin
            owner_d = REQ_LD;
        end else if (dm_gnt) begin
            owner_d = REQ_DM;
        end else if (if_gnt) begin
            owner_d = REQ_IF;
        end
        // Counter saturates so a fetch that has waited long enough keeps top data priority.
        if (bus.if_req && !if_gnt) begin
            starve_cnt_d = fetch_urgent ? starve_cnt_q : starve_cnt_q + 3'd1;
        end
        if (bus.dm_req && bus.if_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
        if (rst) begin
            owner_d        = REQ_LD;
            rvalid_d       = 1'b0;
            starve_cnt_d   = 3'd0;
            conflict_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk1) begin
        owner_q        <= owner_d;
        rvalid_q       <= rvalid_d;
        starve_cnt_q   <= starve_cnt_d;
        conflict_cnt_q <= conflict_cnt_d;
    end

    mips_mem_bank #(.AW(AW), .DW(DW)) u_bank (
        .clk   (clk1),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (bus.rdata)
    );

    // A read still in flight when reset arrives must not be reported to its requester.
    assign bus.ld_gnt    = ld_gnt;
    assign bus.dm_gnt    = dm_gnt;
    assign bus.if_gnt    = if_gnt;
    assign bus.ld_rvalid = rvalid_q && (owner_q == REQ_LD) && !rst;
    assign bus.dm_rvalid = rvalid_q && (owner_q == REQ_DM) && !rst;
    assign bus.if_rvalid = rvalid_q && (owner_q == REQ_IF) && !rst;
    assign conflict_cnt  = conflict_cnt_q;
endmodule
